// File: rtl/render_ctrl.sv
// render_ctrl: sequences one CLEAR/DRAW command and muxes the active engine onto the framebuffer write port.
// Latency: fb_we/fb_addr/fb_data/clear_enable/draw_stall are combinational; op_done/op_err/draw_start are registered (+1 cycle).
// Backpressure: fb_ready low holds clear counters or the draw pixel; cmd_ready low (command held upstream) while busy.
// Optional draw watchdog enabled by defining RENDER_WDOG_EN; the default build has no watchdog.
module render_ctrl #(
    parameter int SCR_W       = 320,
    parameter int SCR_H       = 240,
    parameter int ADDR_W      = 17,
    parameter int COLOR_W     = 8,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               n_rst,
    // command interface
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_op,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic               cmd_ready,
    // clear scan engine
    output logic               clear_enable,
    input  logic               clear_done,
    input  logic [8:0]         cx,
    input  logic [7:0]         cy,
    // draw engine
    output logic               draw_start,
    input  logic               draw_valid,
    input  logic [8:0]         dx,
    input  logic [7:0]         dy,
    output logic               draw_stall,
    input  logic               draw_done,
    output logic               draw_abort,
    // framebuffer write port
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    input  logic               fb_ready,
    // status
    output logic               busy,
    output logic               op_done,
    output logic               op_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAW  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               op_done_q, op_done_d;
    logic               op_err_q, op_err_d;
    logic               draw_start_q, draw_start_d;

    logic [8:0]         pix_x;
    logic [7:0]         pix_y;
    logic [ADDR_W-1:0]  x_ext;
    logic [ADDR_W-1:0]  y_ext;
    logic               draw_in_bounds;
    logic               draw_accept;
    logic               wdog_hit;

    // A draw pixel is consumed whenever the port is ready, even if it is dropped as off-screen.
    assign draw_in_bounds = (int'(dx) < SCR_W) && (int'(dy) < SCR_H);
    assign draw_accept    = (state_q == ST_DRAW) && draw_valid && fb_ready;

    // Port mux: the active engine owns the write strobe and the pixel coordinates.
    always_comb begin
        clear_enable = 1'b0;
        draw_stall   = 1'b0;
        fb_we        = 1'b0;
        pix_x        = '0;
        pix_y        = '0;
        unique case (state_q)
            ST_CLEAR: begin
                clear_enable = fb_ready;
                fb_we        = fb_ready;
                pix_x        = cx;
                pix_y        = cy;
            end
            ST_DRAW: begin
                draw_stall = !fb_ready;
                fb_we      = draw_valid && fb_ready && draw_in_bounds;
                pix_x      = dx;
                pix_y      = dy;
            end
            default: begin
                clear_enable = 1'b0;
            end
        endcase
    end

    assign x_ext = ADDR_W'(pix_x);
    assign y_ext = ADDR_W'(pix_y);

    // Linear address y*SCR_W + x; the 320-wide screen uses a shift-add (256 + 64).
    generate
        if (SCR_W == 320) begin : g_addr_320
            assign fb_addr = (y_ext << 8) + (y_ext << 6) + x_ext;
        end else begin : g_addr_mul
            assign fb_addr = (y_ext * ADDR_W'(SCR_W)) + x_ext;
        end
    endgenerate

    assign fb_data   = fb_we ? color_q : '0;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

`ifdef RENDER_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;

    // Idle-cycle counter: cleared outside DRAW (so it starts at 0 on entry) and on every consumed pixel.
    always_comb begin
        wdog_cnt_d = '0;
        if ((state_q == ST_DRAW) && !draw_accept) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
    end

    // The counter value equals the number of idle DRAW cycles already seen, so the limit is hit on cycle WDOG_CYCLES.
    assign wdog_hit   = (state_q == ST_DRAW) && !draw_accept && !draw_done &&
                        (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));
    assign draw_abort = wdog_hit;

    // Watchdog counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
        end
    end
`else
    assign wdog_hit   = 1'b0;
    assign draw_abort = 1'b0;
`endif

    // Command sequencing: next state, latched colour and the completion/error pulses.
    always_comb begin
        state_d      = state_q;
        color_d      = color_q;
        op_done_d    = 1'b0;
        op_err_d     = 1'b0;
        draw_start_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    color_d = cmd_color;
                    unique case (cmd_op)
                        2'd1: state_d = ST_CLEAR;
                        2'd2: begin
                            state_d      = ST_DRAW;
                            draw_start_d = 1'b1;
                        end
                        2'd3: op_err_d = 1'b1;
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_CLEAR: begin
                if (clear_done) begin
                    state_d   = ST_IDLE;
                    op_done_d = 1'b1;
                end
            end
            ST_DRAW: begin
                // A pixel presented alongside draw_done is written this cycle by the port mux.
                if (draw_done) begin
                    state_d   = ST_IDLE;
                    op_done_d = 1'b1;
                end else if (wdog_hit) begin
                    state_d  = ST_IDLE;
                    op_err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            color_q      <= '0;
            op_done_q    <= 1'b0;
            op_err_q     <= 1'b0;
            draw_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            color_q      <= color_d;
            op_done_q    <= op_done_d;
            op_err_q     <= op_err_d;
            draw_start_q <= draw_start_d;
        end
    end

    assign op_done    = op_done_q;
    assign op_err     = op_err_q;
    assign draw_start = draw_start_q;

endmodule

// File: tb/tb_render_ctrl.sv
// tb_render_ctrl: directed + randomized checks of render_ctrl against a pixel-level reference model.
// Latency: expects zero-latency port outputs and one-cycle op_done/op_err/draw_start pulses.
// Backpressure: fb_ready drops (forced and random) must hold the clear scan and the draw pixel.
module tb_render_ctrl;

    localparam int SCR_W   = 320;
    localparam int SCR_H   = 240;
    localparam int ADDR_W  = 17;
    localparam int COLOR_W = 8;
    localparam int NPIX    = SCR_W * SCR_H;

    logic               clk = 1'b0;
    logic               n_rst = 1'b0;
    logic               cmd_valid = 1'b0;
    logic [1:0]         cmd_op = 2'd0;
    logic [COLOR_W-1:0] cmd_color = '0;
    logic               cmd_ready;
    logic               clear_enable;
    logic               clear_done;
    logic [8:0]         cx;
    logic [7:0]         cy;
    logic               draw_start;
    logic               draw_valid = 1'b0;
    logic [8:0]         dx = '0;
    logic [7:0]         dy = '0;
    logic               draw_stall;
    logic               draw_done = 1'b0;
    logic               draw_abort;
    logic               fb_we;
    logic [ADDR_W-1:0]  fb_addr;
    logic [COLOR_W-1:0] fb_data;
    logic               fb_ready = 1'b0;
    logic               busy;
    logic               op_done;
    logic               op_err;

    int compared   = 0;
    int mismatched = 0;
    int model_writes;
    int dut_writes;

    always #5 clk = ~clk;

    render_ctrl #(
        .SCR_W(SCR_W), .SCR_H(SCR_H), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .WDOG_CYCLES(1024)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_color(cmd_color), .cmd_ready(cmd_ready),
        .clear_enable(clear_enable), .clear_done(clear_done), .cx(cx), .cy(cy),
        .draw_start(draw_start), .draw_valid(draw_valid), .dx(dx), .dy(dy),
        .draw_stall(draw_stall), .draw_done(draw_done), .draw_abort(draw_abort),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
        .busy(busy), .op_done(op_done), .op_err(op_err)
    );

    // Clear scan engine stand-in: raster counters advanced by clear_enable, done with the last pixel.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cx <= '0;
            cy <= '0;
        end else if (clear_enable) begin
            if (cx == 9'(SCR_W - 1)) begin
                cx <= '0;
                cy <= (cy == 8'(SCR_H - 1)) ? 8'd0 : cy + 8'd1;
            end else begin
                cx <= cx + 9'd1;
            end
        end
    end
    assign clear_done = clear_enable && (cx == 9'(SCR_W - 1)) && (cy == 8'(SCR_H - 1));

    // Hard stop in case something stalls the sequence.
    initial begin
        #3000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [COLOR_W-1:0] col);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_color = col;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
    endtask

    // One DRAW-state cycle checked against the pixel rules: on-screen + valid + ready -> write at y*W+x.
    task automatic draw_cycle(input bit vld, input int x, input int y, input bit rdy,
                              input bit done, input logic [COLOR_W-1:0] col);
        bit we_exp;
        draw_valid = vld;
        dx         = 9'(x);
        dy         = 8'(y);
        fb_ready   = rdy;
        draw_done  = done;
        we_exp     = vld && rdy && (x < SCR_W) && (y < SCR_H);
        @(negedge clk);
        chk("draw_stall", draw_stall, !rdy);
        chk("draw_we", fb_we, we_exp);
        if (we_exp) begin
            chk("draw_addr", fb_addr, y * SCR_W + x);
            chk("draw_data", fb_data, col);
            model_writes++;
        end else begin
            chk("draw_data_nowrite", fb_data, 0);
        end
        if (fb_we === 1'b1) dut_writes++;
        tick();
        draw_valid = 1'b0;
        draw_done  = 1'b0;
    endtask

    initial begin : main
        int exp_addr;
        int cyc;
        int stall;
        int x;
        int y;
        int k;
        bit rdy;
        logic [COLOR_W-1:0] col;
        int px [4];
        int py [4];

        // reset state
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_data", fb_data, 0);
        chk("rst_clear_enable", clear_enable, 0);
        chk("rst_draw_start", draw_start, 0);
        chk("rst_op_done", op_done, 0);
        chk("rst_op_err", op_err, 0);
        tick();
        n_rst = 1'b1;

        // illegal op: consumed, error pulse, stays idle
        issue(2'd3, 8'h77);
        @(negedge clk);
        chk("ill_op_err", op_err, 1);
        chk("ill_busy", busy, 0);
        chk("ill_cmd_ready", cmd_ready, 1);
        chk("ill_op_done", op_done, 0);
        tick();
        @(negedge clk);
        chk("ill_op_err_pulse", op_err, 0);
        tick();

        // NOP: consumed silently
        issue(2'd0, 8'h12);
        @(negedge clk);
        chk("nop_busy", busy, 0);
        chk("nop_op_done", op_done, 0);
        chk("nop_op_err", op_err, 0);
        tick();

        // full CLEAR 0x3C with a forced 5-cycle stall at address 1000, random drops, and a CLEAR held off while busy
        issue(2'd1, 8'h3C);
        exp_addr = 0;
        cyc      = 0;
        stall    = 0;
        while (exp_addr < NPIX && cyc < 90000) begin
            cyc++;
            if (exp_addr == 1000 && stall < 5) begin
                fb_ready = 1'b0;
                stall++;
            end else begin
                fb_ready = ($urandom_range(0, 99) >= 2);
            end
            if (cyc == 100) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'd1;
                cmd_color = 8'h55;
            end
            @(negedge clk);
            chk("clr_enable", clear_enable, fb_ready);
            chk("clr_we", fb_we, fb_ready);
            if (cyc >= 100) chk("clr_held_cmd_ready", cmd_ready, 0);
            if (fb_ready) begin
                chk("clr_addr", fb_addr, exp_addr);
                chk("clr_data", fb_data, 8'h3C);
                exp_addr++;
            end else begin
                chk("clr_stall_data", fb_data, 0);
            end
            tick();
        end
        chk("clr_pixel_count", exp_addr, NPIX);
        chk("clr_stall_seen", stall, 5);
        @(negedge clk);
        chk("clr_op_done", op_done, 1);
        chk("clr_idle", busy, 0);
        chk("clr_held_accept_rdy", cmd_ready, 1);
        chk("clr_idle_we", fb_we, 0);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        fb_ready  = 1'b1;

        // the held CLEAR starts now; reset it part-way through
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("clr2_busy", busy, 1);
            chk("clr2_addr", fb_addr, i);
            chk("clr2_data", fb_data, 8'h55);
            chk("clr2_op_done", op_done, 0);
            tick();
        end
        #2;
        n_rst = 1'b0;
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_cmd_ready", cmd_ready, 1);
        chk("mrst_fb_we", fb_we, 0);
        chk("mrst_clear_enable", clear_enable, 0);
        chk("mrst_fb_addr", fb_addr, 0);
        chk("mrst_fb_data", fb_data, 0);
        chk("mrst_op_done", op_done, 0);
        chk("mrst_op_err", op_err, 0);
        tick();
        n_rst = 1'b1;
        @(negedge clk);
        chk("mrst_after_busy", busy, 0);
        chk("mrst_after_op_done", op_done, 0);
        tick();

        // directed DRAW: only (10,5) and (319,239) land; last pixel comes with draw_done
        model_writes = 0;
        dut_writes   = 0;
        px = '{10, 320, 0, 319};
        py = '{5, 10, 240, 239};
        issue(2'd2, 8'hA5);
        @(negedge clk);
        chk("drw_start", draw_start, 1);
        chk("drw_busy", busy, 1);
        chk("drw_cmd_ready", cmd_ready, 0);
        tick();
        @(negedge clk);
        chk("drw_start_pulse", draw_start, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            draw_cycle(1'b1, px[i], py[i], 1'b1, (i == 3), 8'hA5);
        end
        @(negedge clk);
        chk("drw_op_done", op_done, 1);
        chk("drw_idle", busy, 0);
        chk("drw_write_count", dut_writes, 2);
        tick();

        // randomized DRAW with random fb_ready stalls and off-screen pixels
        model_writes = 0;
        dut_writes   = 0;
        col = 8'($urandom_range(1, 255));
        issue(2'd2, col);
        for (int i = 0; i < 150; i++) begin
            x = $urandom_range(0, 340);
            y = $urandom_range(0, 255);
            if ($urandom_range(0, 4) == 0) draw_cycle(1'b0, x, y, 1'b1, 1'b0, col);
            k = 0;
            do begin
                rdy = ($urandom_range(0, 3) != 0) || (k >= 20);
                draw_cycle(1'b1, x, y, rdy, 1'b0, col);
                k++;
            end while (!rdy);
        end
        chk("rnd_no_abort", draw_abort, 0);
        draw_cycle(1'b0, 0, 0, 1'b1, 1'b1, col);
        @(negedge clk);
        chk("rnd_op_done", op_done, 1);
        chk("rnd_idle", busy, 0);
        chk("rnd_op_err", op_err, 0);
        chk("rnd_write_count", dut_writes, model_writes);
        tick();
        @(negedge clk);
        chk("rnd_op_done_pulse", op_done, 0);
        tick();

`ifdef RENDER_WDOG_EN
        // watchdog: DRAW with no engine activity aborts on cycle 1024
        issue(2'd2, 8'h0F);
        cyc = 0;
        k   = 0;
        while (cyc < 1100 && k == 0) begin
            cyc++;
            @(negedge clk);
            if (draw_abort === 1'b1) k = 1;
            else tick();
        end
        chk("wdog_abort_cycle", cyc, 1024);
        tick();
        @(negedge clk);
        chk("wdog_op_err", op_err, 1);
        chk("wdog_no_op_done", op_done, 0);
        chk("wdog_idle", busy, 0);
        chk("wdog_abort_pulse", draw_abort, 0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
